// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch front end: PC register, imem request handshake, and the IF/ID
// valid/ready register backed by a one-entry skid buffer. Handles redirect flush/drain.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_cur,
    input  logic [31:0] pc_plus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr,
    input  logic        id_ready
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StStall,
        StDrain
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic [31:0] skid_instr_q, skid_instr_d;

    logic transfer;
    logic slot_free;

    assign transfer  = ifid_valid_q & id_ready;
    assign slot_free = ~ifid_valid_q | id_ready;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_pc4_d   = skid_pc4_q;
        skid_instr_d = skid_instr_q;

        // A consumed entry empties the slot unless a reload below refills it.
        if (transfer) begin
            ifid_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                state_d    = StFetch;
                req_addr_d = redirect_valid ? redirect_pc : pc_q;
            end

            StFetch: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        req_addr_d = redirect_pc;
                    end else if (slot_free) begin
                        ifid_valid_d = 1'b1;
                        ifid_pc_d    = req_addr_q;
                        ifid_pc4_d   = pc_plus4;
                        ifid_instr_d = imem_rdata;
                        pc_d         = pc_plus4;
                        req_addr_d   = pc_plus4;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_pc_d    = req_addr_q;
                        skid_pc4_d   = pc_plus4;
                        skid_instr_d = imem_rdata;
                        pc_d         = pc_plus4;
                        state_d      = StStall;
                    end
                end else if (redirect_valid) begin
                    // Request cannot be abandoned; wait out its ack at the stale address.
                    state_d = StDrain;
                end
            end

            StStall: begin
                if (redirect_valid) begin
                    req_addr_d = redirect_pc;
                    state_d    = StFetch;
                end else if (id_ready) begin
                    ifid_valid_d = 1'b1;
                    ifid_pc_d    = skid_pc_q;
                    ifid_pc4_d   = skid_pc4_q;
                    ifid_instr_d = skid_instr_q;
                    skid_valid_d = 1'b0;
                    req_addr_d   = pc_q;
                    state_d      = StFetch;
                end
            end

            StDrain: begin
                if (imem_ack) begin
                    req_addr_d = redirect_valid ? redirect_pc : pc_q;
                    state_d    = StFetch;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Redirect overrides every other update to the PC and the pipeline register.
        if (redirect_valid) begin
            pc_d         = redirect_pc;
            ifid_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 32'h0;
            ifid_pc4_q   <= 32'h0;
            ifid_instr_q <= 32'h0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= 32'h0;
            skid_pc4_q   <= 32'h0;
            skid_instr_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_pc4_q   <= skid_pc4_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    assign pc_cur     = pc_q;
    assign imem_req   = (state_q == StFetch) || (state_q == StDrain);
    assign imem_addr  = req_addr_q;
    assign ifid_valid = ifid_valid_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign ifid_instr = ifid_instr_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenario tasks plus a scoreboard that checks every
// entry ID accepts against the expected fetch order.
module tb_if_fetch_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_cur, pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_pc, ifid_pc4, ifid_instr;
    logic        id_ready;

    // Second instance with a non-zero reset PC; only its reset/first request are checked.
    logic [31:0] b_pc_cur, b_pc_plus4, b_imem_addr, b_ifid_pc, b_ifid_pc4, b_ifid_instr;
    logic        b_imem_req, b_ifid_valid;

    int n_checks = 0;
    int n_fails  = 0;
    entry_t exp_q[$];

    always #5 clk = ~clk;

    assign pc_plus4   = pc_cur + 32'd4;
    assign b_pc_plus4 = b_pc_cur + 32'd4;

    if_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_plus4(pc_plus4),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ifid_valid(ifid_valid), .ifid_pc(ifid_pc),
        .ifid_pc4(ifid_pc4), .ifid_instr(ifid_instr), .id_ready(id_ready)
    );

    if_fetch_ctrl #(.RESET_PC(32'h0040_0000)) dut_b (
        .clk(clk), .rst(rst), .pc_cur(b_pc_cur), .pc_plus4(b_pc_plus4),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(b_imem_req), .imem_addr(b_imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ifid_valid(b_ifid_valid), .ifid_pc(b_ifid_pc),
        .ifid_pc4(b_ifid_pc4), .ifid_instr(b_ifid_instr), .id_ready(id_ready)
    );

    // Inputs change 1 time unit after posedge, so negedge sees a settled transfer.
    always @(negedge clk) begin
        entry_t got, want;
        if (ifid_valid === 1'b1 && id_ready === 1'b1) begin
            got = '{pc: ifid_pc, pc4: ifid_pc4, instr: ifid_instr};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, want no transfer",
                         ifid_pc, ifid_instr);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_fails++;
                    $display("FAIL sb_entry: got pc=%h pc4=%h instr=%h, want pc=%h pc4=%h instr=%h",
                             got.pc, got.pc4, got.instr, want.pc, want.pc4, want.instr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0; id_ready = 1'b1;
        tick(); tick();
        n_checks++; if (imem_req !== 1'b0) begin n_fails++; $display("FAIL rst_req: got %b want 0", imem_req); end
        n_checks++; if (pc_cur !== 32'h0) begin n_fails++; $display("FAIL rst_pc: got %h want 0", pc_cur); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fails++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        n_checks++; if ({ifid_valid, ifid_pc, ifid_pc4, ifid_instr} !== 97'h0) begin n_fails++; $display("FAIL rst_ifid: got v=%b pc=%h pc4=%h i=%h want all 0", ifid_valid, ifid_pc, ifid_pc4, ifid_instr); end
        n_checks++; if (b_pc_cur !== 32'h0040_0000) begin n_fails++; $display("FAIL rst_b_pc: got %h want 00400000", b_pc_cur); end
        rst = 1'b0;
        tick();
        n_checks++; if (imem_req !== 1'b1) begin n_fails++; $display("FAIL first_req: got %b want 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fails++; $display("FAIL first_addr: got %h want 0", imem_addr); end
        n_checks++; if (b_imem_req !== 1'b1 || b_imem_addr !== 32'h0040_0000) begin n_fails++; $display("FAIL first_b_addr: got req=%b addr=%h want 1 00400000", b_imem_req, b_imem_addr); end
    endtask

    task automatic test_back_to_back();
        imem_ack = 1'b1; imem_rdata = 32'h2002_000A;
        exp_q.push_back('{pc: 32'h0, pc4: 32'h4, instr: 32'h2002_000A});
        tick();
        n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0 || ifid_pc4 !== 32'h4 || ifid_instr !== 32'h2002_000A) begin n_fails++; $display("FAIL b2b_ifid: got v=%b pc=%h pc4=%h i=%h want 1 0 4 2002000a", ifid_valid, ifid_pc, ifid_pc4, ifid_instr); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fails++; $display("FAIL b2b_addr: got req=%b addr=%h want 1 4", imem_req, imem_addr); end
    endtask

    task automatic test_stall();
        id_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h2003_0005;
        exp_q.push_back('{pc: 32'h4, pc4: 32'h8, instr: 32'h2003_0005});
        tick();
        imem_ack = 1'b0;
        n_checks++; if (imem_req !== 1'b0 || ifid_pc !== 32'h0 || ifid_valid !== 1'b1) begin n_fails++; $display("FAIL stall_enter: got req=%b v=%b pc=%h want 0 1 0", imem_req, ifid_valid, ifid_pc); end
        n_checks++; if (pc_cur !== 32'h8) begin n_fails++; $display("FAIL stall_pc: got %h want 8", pc_cur); end
        tick();
        n_checks++; if (imem_req !== 1'b0 || ifid_pc !== 32'h0) begin n_fails++; $display("FAIL stall_hold: got req=%b pc=%h want 0 0", imem_req, ifid_pc); end
        id_ready = 1'b1;
        tick();
        n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h4 || ifid_instr !== 32'h2003_0005) begin n_fails++; $display("FAIL stall_skid: got v=%b pc=%h i=%h want 1 4 20030005", ifid_valid, ifid_pc, ifid_instr); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fails++; $display("FAIL stall_resume: got req=%b addr=%h want 1 8", imem_req, imem_addr); end
    endtask

    task automatic test_drain();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || ifid_valid !== 1'b0) begin n_fails++; $display("FAIL drain_enter: got req=%b addr=%h v=%b want 1 8 0", imem_req, imem_addr, ifid_valid); end
        n_checks++; if (pc_cur !== 32'h40) begin n_fails++; $display("FAIL drain_pc: got %h want 40", pc_cur); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fails++; $display("FAIL drain_hold%0d: got req=%b addr=%h want 1 8", i, imem_req, imem_addr); end
        end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || pc_cur !== 32'h40) begin n_fails++; $display("FAIL drain_exit: got req=%b addr=%h pc=%h want 1 40 40", imem_req, imem_addr, pc_cur); end
        n_checks++; if (ifid_valid !== 1'b0) begin n_fails++; $display("FAIL drain_drop: got v=%b want 0", ifid_valid); end
    endtask

    task automatic test_redirect_ack();
        imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
        exp_q.push_back('{pc: 32'h40, pc4: 32'h44, instr: 32'h1111_1111});
        tick();
        n_checks++; if (ifid_pc !== 32'h40 || imem_addr !== 32'h44) begin n_fails++; $display("FAIL ra_load: got pc=%h addr=%h want 40 44", ifid_pc, imem_addr); end
        imem_rdata = 32'h2222_2222; redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        imem_ack = 1'b0; redirect_valid = 1'b0;
        n_checks++; if (ifid_valid !== 1'b0 || ifid_instr === 32'h2222_2222) begin n_fails++; $display("FAIL ra_flush: got v=%b i=%h want 0 and not 22222222", ifid_valid, ifid_instr); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80 || pc_cur !== 32'h80) begin n_fails++; $display("FAIL ra_addr: got req=%b addr=%h pc=%h want 1 80 80", imem_req, imem_addr, pc_cur); end
    endtask

    task automatic test_stall_redirect();
        id_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h3333_3333;
        exp_q.push_back('{pc: 32'h80, pc4: 32'h84, instr: 32'h3333_3333});
        tick();
        imem_rdata = 32'h4444_4444;
        exp_q.push_back('{pc: 32'h84, pc4: 32'h88, instr: 32'h4444_4444});
        tick();
        imem_ack = 1'b0;
        n_checks++; if (imem_req !== 1'b0 || ifid_pc !== 32'h80) begin n_fails++; $display("FAIL sr_stall: got req=%b pc=%h want 0 80", imem_req, ifid_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        // Both the IF/ID entry and the skid entry are flushed without ever transferring.
        n_checks++; if (exp_q.size() != 2) begin n_fails++; $display("FAIL sr_queue: got %0d pending want 2", exp_q.size()); end
        exp_q.delete();
        n_checks++; if (ifid_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fails++; $display("FAIL sr_flush: got v=%b req=%b addr=%h want 0 1 100", ifid_valid, imem_req, imem_addr); end
        id_ready = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
        exp_q.push_back('{pc: 32'h100, pc4: 32'h104, instr: 32'h5555_5555});
        tick();
        imem_ack = 1'b0;
        n_checks++; if (ifid_pc !== 32'h100 || ifid_instr !== 32'h5555_5555) begin n_fails++; $display("FAIL sr_after: got pc=%h i=%h want 100 55555555", ifid_pc, ifid_instr); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_ack = 1'b1; imem_rdata = 32'h9999_9999;
        tick();
        redirect_valid = 1'b0; imem_rdata = 32'h7777_7777;
        exp_q.push_back('{pc: 32'hFFFF_FFFC, pc4: 32'h0, instr: 32'h7777_7777});
        tick();
        imem_ack = 1'b0;
        n_checks++; if (ifid_pc !== 32'hFFFF_FFFC || ifid_pc4 !== 32'h0) begin n_fails++; $display("FAIL wrap_ifid: got pc=%h pc4=%h want fffffffc 0", ifid_pc, ifid_pc4); end
        n_checks++; if (imem_addr !== 32'h0 || pc_cur !== 32'h0) begin n_fails++; $display("FAIL wrap_addr: got addr=%h pc=%h want 0 0", imem_addr, pc_cur); end
    endtask

    task automatic test_reset_drain();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || pc_cur !== 32'h200) begin n_fails++; $display("FAIL rd_drain: got req=%b addr=%h pc=%h want 1 0 200", imem_req, imem_addr, pc_cur); end
        rst = 1'b1;
        tick();
        n_checks++; if (imem_req !== 1'b0 || pc_cur !== 32'h0 || ifid_valid !== 1'b0) begin n_fails++; $display("FAIL rd_reset: got req=%b pc=%h v=%b want 0 0 0", imem_req, pc_cur, ifid_valid); end
        n_checks++; if (b_imem_req !== 1'b0 || b_pc_cur !== 32'h0040_0000) begin n_fails++; $display("FAIL rd_b_reset: got req=%b pc=%h want 0 00400000", b_imem_req, b_pc_cur); end
        rst = 1'b0;
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fails++; $display("FAIL rd_restart: got req=%b addr=%h want 1 0", imem_req, imem_addr); end
        n_checks++; if (b_imem_req !== 1'b1 || b_imem_addr !== 32'h0040_0000) begin n_fails++; $display("FAIL rd_b_restart: got req=%b addr=%h want 1 00400000", b_imem_req, b_imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h6666_6666;
        exp_q.push_back('{pc: 32'h0, pc4: 32'h4, instr: 32'h6666_6666});
        tick();
        imem_ack = 1'b0;
        n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0 || ifid_instr !== 32'h6666_6666) begin n_fails++; $display("FAIL rd_first: got v=%b pc=%h i=%h want 1 0 66666666", ifid_valid, ifid_pc, ifid_instr); end
        tick(); tick();
        n_checks++; if (exp_q.size() != 0) begin n_fails++; $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_drain();
        test_redirect_ack();
        test_stall_redirect();
        test_wrap();
        test_reset_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Instruction-fetch front end of the 5-stage pipeline.
- Owns the PC register and drives the instruction-memory request handshake. Feeds the current PC to the IF-stage PC+4 adder and consumes that adder's sum as the sequential next PC.
- Delivers fetched instructions to ID through a valid/ready IF/ID register with a one-entry skid buffer.
- Handles branch/jump redirects, including flushing and draining an in-flight memory request.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
pc_cur  output  32  current PC; drives PC+4 adder input
pc_plus4  input  32  PC+4 adder output; always equals pc_cur+4
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  32  redirect target
imem_req  output  1  instruction memory request
imem_addr  output  32  request address; stable while imem_req=1
imem_ack  input  1  memory returns data this cycle; single-cycle pulse
imem_rdata  input  32  instruction word, valid when imem_ack=1
ifid_valid  output  1  IF/ID entry valid
ifid_pc  output  32  PC of the IF/ID instruction
ifid_pc4  output  32  PC+4 of the IF/ID instruction
ifid_instr  output  32  instruction word
id_ready  input  1  ID accepts the entry this cycle (transfer = ifid_valid & id_ready)

Behaviour:
- Clock and reset: single clock `clk`. `rst` is synchronous and active-high.
- Reset values: state=IDLE; pc_cur=RESET_PC; req_addr (drives imem_addr)=RESET_PC; imem_req=0; ifid_valid=0; ifid_pc=ifid_pc4=ifid_instr=0; skid empty.
- imem_req = (state==FETCH || state==DRAIN). It is combinational from state, so it is 0 while in reset.
- Memory rule: once imem_req=1, imem_req and imem_addr hold until imem_ack. A request is never abandoned.
- slot_free = !ifid_valid || id_ready.
- Redirect has priority over all other updates:
  - pc_cur <= redirect_pc
  - ifid_valid <= 0
  - skid dropped
- If a transfer occurs and the IF/ID register is not reloaded in the same cycle, ifid_valid <= 0.
- States:
  - IDLE: req=0.
    - Next cycle go to FETCH.
    - req_addr <= redirect_valid ? redirect_pc : pc_cur.
  - FETCH: req=1; pc_cur==req_addr.
    - ack & redirect: discard rdata; req_addr <= redirect_pc; stay FETCH.
    - ack & !redirect & slot_free: ifid <= {1, req_addr, pc_plus4, rdata}; pc_cur, req_addr <= pc_plus4; stay FETCH (back-to-back, 1 instr/cycle at zero-wait memory).
    - ack & !redirect & !slot_free: skid <= {req_addr, pc_plus4, rdata}; pc_cur <= pc_plus4; go to STALL.
    - !ack & redirect: go to DRAIN; req_addr unchanged.
    - !ack & !redirect: hold.
  - STALL: req=0; skid full.
    - redirect: go to FETCH; req_addr <= redirect_pc.
    - id_ready: ifid <= skid (valid=1); skid emptied; req_addr <= pc_cur; go to FETCH.
    - else: hold.
  - DRAIN: req=1 at the stale req_addr; IF/ID stays empty.
    - ack: discard rdata; req_addr <= (redirect ? redirect_pc : pc_cur); go to FETCH.
    - redirect without ack: update pc_cur only; stay DRAIN.
- Latency: zero-wait memory gives IF/ID valid 1 cycle after the ack cycle's request. First instruction appears on ifid 2 cycles after rst deasserts (IDLE, then FETCH+ack).
- Wrap-around: 32-bit PC wraps modulo 2^32 via the adder; no special case.
- Simultaneous events:
  - Redirect and transfer in the same cycle: the flush wins; no new entry is loaded.
  - Redirect and ack in the same cycle: data discarded, never reaches ifid.
- Reset mid-operation (any state): return to reset values next cycle. Any outstanding memory response after reset is the memory's responsibility to cancel (memory shares rst).

Test Plan:
1. Reset release, zero-wait memory, ack on every request, rdata 0x2002000A then 0x20030005 -> cycle after rst: imem_req=1, imem_addr=0. Next: ifid_valid=1, ifid_pc=0, ifid_pc4=4, ifid_instr=0x2002000A, imem_addr=4.
2. id_ready=0 while the fetch at 4 is acked -> STALL, imem_req=0, ifid still pc=0. Raise id_ready -> ifid_pc=4, ifid_instr=0x20030005; next request imem_addr=8.
3. Request at 8 pending without ack, redirect_pc=0x40 -> DRAIN: imem_req=1, imem_addr=8, ifid_valid=0. Ack 3 cycles later: data dropped, next imem_addr=0x40, pc_cur=0x40.
4. Redirect to 0x80 in the same cycle as ack at 0x44 -> ifid_valid=0, 0x44 data never on ifid, next imem_addr=0x80.
5. Redirect to 0x100 while in STALL with skid full -> skid dropped, ifid_valid=0, next cycle imem_req=1, imem_addr=0x100.
6. rst asserted during DRAIN -> next cycle imem_req=0, pc_cur=RESET_PC, ifid_valid=0. After rst release, fetch restarts at RESET_PC. Also run with RESET_PC=0x00400000 and confirm the first request address is 0x00400000.
